pipe_interlock_ctrl: RTL and testbench
======================================

Name: pipe_interlock_ctrl

Overview:
Consumer side of the SimpleRISC load-use hazard request. It takes the combinational stall request from the OF/EX hazard detector and the taken-branch signal from EX. It then sequences the pipeline controls: PC enable, IF/OF latch enable, IF/OF flush, and NOP-bubble insertion into the OF/EX latch. It also keeps saturating stall and flush performance counters. It sits in the top-level pipeline between the hazard detector / branch unit and the pipeline registers.

Parameters:
STALL_CYCLES, 1, bubbles inserted per load-use hazard (1 with MA→EX forwarding, up to 3 without); legal range 1..3
CNT_W, 16, width of the performance counters

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-high reset
add_stall  input  1  load-use hazard request from detector (combinational, ld in EX, dependent consumer in OF)
isBranchTaken_E  input  1  taken branch/call/ret resolved in EX this cycle
cnt_clr  input  1  synchronous clear of both counters
pc_en  output  1  PC register load enable
if_of_en  output  1  IF/OF latch load enable
if_of_flush  output  1  IF/OF latch loads NOP this edge
of_ex_bubble  output  1  OF/EX latch loads NOP (0x68000000) instead of OF contents
stalled  output  1  high while the FSM is in STALL state (debug)
stall_count  output  CNT_W  bubble cycles inserted due to hazards, saturating
flush_count  output  CNT_W  taken-branch flushes, saturating

Behaviour:
- Reset (async, rst=1): state=RUN, remaining=0, stall_count=0, flush_count=0. Outputs read pc_en=1, if_of_en=1, if_of_flush=0, of_ex_bubble=0, stalled=0 (assuming add_stall=0 and isBranchTaken_E=0).
- Control outputs are Mealy: a combinational function of the registered state and the current inputs. Zero-cycle latency from add_stall / isBranchTaken_E to the controls.
- States: RUN, STALL. remaining counter has width $clog2(STALL_CYCLES+1).
- RUN, isBranchTaken_E=1 (priority over add_stall):
  - pc_en=1, if_of_en=1, if_of_flush=1, of_ex_bubble=1.
  - flush_count+1. Next state RUN.
  - add_stall in the same cycle is ignored; the dependent instruction is squashed.
- RUN, add_stall=1, no branch:
  - pc_en=0, if_of_en=0, of_ex_bubble=1, if_of_flush=0.
  - stall_count+1.
  - If STALL_CYCLES=1: next state RUN. Otherwise: next state STALL with remaining=STALL_CYCLES-1.
- RUN, neither input: all enables 1, no flush, no bubble.
- STALL (stalled=1):
  - Outputs are pc_en=0, if_of_en=0, of_ex_bubble=1. stall_count+1. remaining-1.
  - When remaining reaches 1 this cycle, next state is RUN.
  - add_stall is ignored in STALL; the detector sees a bubble in EX.
- STALL with isBranchTaken_E=1: cannot occur with a legal detector, since EX holds a bubble. If it is asserted anyway:
  - The branch wins and the flush outputs from RUN apply.
  - flush_count+1, stall_count is not incremented.
  - The remaining stall is aborted and the next state is RUN.
- Counters:
  - Saturate at all-ones with no wrap.
  - cnt_clr has priority over increment; both counters read 0 next cycle.
  - cnt_clr does not affect the FSM.
- Reset mid-stall: immediate return to RUN with counters zero. The next edge behaves as plain RUN.
- Back-to-back hazards (add_stall in the cycle right after the FSM returns to RUN) start a fresh stall sequence with no gap.

Decomposition:
- Package simplerisc_pkg holds:
  - NOP_INSTR = 32'h6800_0000
  - OPC_LD = 5'b01110
  - branch opcodes: b 10010, beq 10000, bgt 10001, call 10011, ret 10100
  - state enum {RUN, STALL}
- One natural sub-module: sat_counter (CNT_W, inc, clr), instantiated twice for stall_count and flush_count.

Test Plan:
1. Reset: assert rst mid-cycle with add_stall=1 → outputs immediately pc_en=1, if_of_en=1, of_ex_bubble=0; stall_count=0.
2. STALL_CYCLES=1, single add_stall pulse for 1 cycle → that cycle pc_en=0, if_of_en=0, of_ex_bubble=1; next cycle all enables 1; stall_count=1.
3. STALL_CYCLES=3, add_stall pulse for 1 cycle → pc_en=0 for exactly 3 consecutive cycles, stalled=1 on cycles 2–3, then RUN; stall_count=3.
4. add_stall=1 and isBranchTaken_E=1 in the same cycle → pc_en=1, if_of_flush=1, of_ex_bubble=1; flush_count=1, stall_count=0, state RUN.
5. Saturation: CNT_W=4, 20 single-cycle hazards → stall_count=15 and holds. Then cnt_clr=1 together with add_stall=1 → stall_count=0 next cycle.
6. STALL_CYCLES=2: hazard, then a new add_stall on the first RUN cycle after return → 4 total bubble cycles with no gap; stall_count=4.

Source files
------------

// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions: instruction constants, opcodes and the
// interlock controller's state type.
package simplerisc_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h6800_0000;

    localparam logic [4:0] OPC_LD   = 5'b01110;
    localparam logic [4:0] OPC_BEQ  = 5'b10000;
    localparam logic [4:0] OPC_BGT  = 5'b10001;
    localparam logic [4:0] OPC_B    = 5'b10010;
    localparam logic [4:0] OPC_CALL = 5'b10011;
    localparam logic [4:0] OPC_RET  = 5'b10100;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } ilk_state_t;

    // True for any opcode that can redirect the PC when resolved in EX.
    function automatic logic is_branch_opc(input logic [4:0] opc);
        return (opc == OPC_B)    || (opc == OPC_BEQ) || (opc == OPC_BGT) ||
               (opc == OPC_CALL) || (opc == OPC_RET);
    endfunction

endpackage

// File: rtl/pipe_interlock_ctrl_if.sv
// Hazard/branch requests in, pipeline latch controls and perf counters out.
// master = pipeline side driving requests, slave = interlock controller.
interface pipe_interlock_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             add_stall;
    logic             isBranchTaken_E;
    logic             cnt_clr;
    logic             pc_en;
    logic             if_of_en;
    logic             if_of_flush;
    logic             of_ex_bubble;
    logic             stalled;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output add_stall, isBranchTaken_E, cnt_clr,
        input  pc_en, if_of_en, if_of_flush, of_ex_bubble, stalled,
               stall_count, flush_count
    );

    modport slave (
        input  add_stall, isBranchTaken_E, cnt_clr,
        output pc_en, if_of_en, if_of_flush, of_ex_bubble, stalled,
               stall_count, flush_count
    );
endinterface

// File: rtl/pipe_interlock_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Count events, stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_interlock_ctrl.sv
// Load-use / taken-branch interlock sequencer for the SimpleRISC pipeline.
// Controls are Mealy so a hazard stalls the front end in the same cycle the
// detector raises it; only the extra bubbles beyond the first need state.
module pipe_interlock_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_interlock_ctrl_if.slave bus
);
    import simplerisc_pkg::*;

    localparam int RW = $clog2(STALL_CYCLES + 1);

    ilk_state_t       state;
    logic [RW-1:0]    remaining;
    logic             pc_en;
    logic             if_of_en;
    logic             if_of_flush;
    logic             of_ex_bubble;
    logic             stall_inc;
    logic             flush_inc;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Decode controls from state and live requests; a taken branch outranks
    // any stall, and reset forces the free-running defaults.
    always_comb begin
        pc_en        = 1'b1;
        if_of_en     = 1'b1;
        if_of_flush  = 1'b0;
        of_ex_bubble = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (!rst) begin
            if (bus.isBranchTaken_E) begin
                if_of_flush  = 1'b1;
                of_ex_bubble = 1'b1;
                flush_inc    = 1'b1;
            end else if ((state == STALL) || bus.add_stall) begin
                pc_en        = 1'b0;
                if_of_en     = 1'b0;
                of_ex_bubble = 1'b1;
                stall_inc    = 1'b1;
            end
        end
    end

    // Track the extra bubble cycles owed after the first one of a hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            remaining <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!bus.isBranchTaken_E && bus.add_stall && (STALL_CYCLES > 1)) begin
                        state     <= STALL;
                        remaining <= RW'(STALL_CYCLES - 1);
                    end
                end
                STALL: begin
                    if (bus.isBranchTaken_E || (remaining == RW'(1))) begin
                        state     <= RUN;
                        remaining <= '0;
                    end else begin
                        remaining <= remaining - 1'b1;
                    end
                end
                default: begin
                    state     <= RUN;
                    remaining <= '0;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .clr   (bus.cnt_clr),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .clr   (bus.cnt_clr),
        .count (flush_cnt)
    );

    assign bus.pc_en        = pc_en;
    assign bus.if_of_en     = if_of_en;
    assign bus.if_of_flush  = if_of_flush;
    assign bus.of_ex_bubble = of_ex_bubble;
    assign bus.stalled      = (state == STALL);
    assign bus.stall_count  = stall_cnt;
    assign bus.flush_count  = flush_cnt;

endmodule

// File: tb/tb_pipe_interlock_ctrl.sv
// Bench for pipe_interlock_ctrl: three instances (STALL_CYCLES 1/3/2) share
// one stimulus stream and are each compared to a cycle-level model.
module tb_pipe_interlock_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic add_stall;
    logic br;
    logic clr;

    always #5 clk = ~clk;

    pipe_interlock_ctrl_if #(.CNT_W(4))  if_a ();
    pipe_interlock_ctrl_if #(.CNT_W(16)) if_b ();
    pipe_interlock_ctrl_if #(.CNT_W(16)) if_c ();

    pipe_interlock_ctrl #(.STALL_CYCLES(1), .CNT_W(4))  dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    pipe_interlock_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    pipe_interlock_ctrl #(.STALL_CYCLES(2), .CNT_W(16)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    assign if_a.add_stall = add_stall;  assign if_a.isBranchTaken_E = br;  assign if_a.cnt_clr = clr;
    assign if_b.add_stall = add_stall;  assign if_b.isBranchTaken_E = br;  assign if_b.cnt_clr = clr;
    assign if_c.add_stall = add_stall;  assign if_c.isBranchTaken_E = br;  assign if_c.cnt_clr = clr;

    logic        o_pc [3];
    logic        o_en [3];
    logic        o_fl [3];
    logic        o_bub[3];
    logic        o_st [3];
    logic [31:0] o_sc [3];
    logic [31:0] o_fc [3];

    assign o_pc[0] = if_a.pc_en;  assign o_en[0] = if_a.if_of_en;  assign o_fl[0] = if_a.if_of_flush;
    assign o_bub[0] = if_a.of_ex_bubble;  assign o_st[0] = if_a.stalled;
    assign o_sc[0] = 32'(if_a.stall_count);  assign o_fc[0] = 32'(if_a.flush_count);
    assign o_pc[1] = if_b.pc_en;  assign o_en[1] = if_b.if_of_en;  assign o_fl[1] = if_b.if_of_flush;
    assign o_bub[1] = if_b.of_ex_bubble;  assign o_st[1] = if_b.stalled;
    assign o_sc[1] = 32'(if_b.stall_count);  assign o_fc[1] = 32'(if_b.flush_count);
    assign o_pc[2] = if_c.pc_en;  assign o_en[2] = if_c.if_of_en;  assign o_fl[2] = if_c.if_of_flush;
    assign o_bub[2] = if_c.of_ex_bubble;  assign o_st[2] = if_c.stalled;
    assign o_sc[2] = 32'(if_c.stall_count);  assign o_fc[2] = 32'(if_c.flush_count);

    int nchk = 0;
    int nerr = 0;

    // Reference model: bubbles still owed, plus plain integer counters.
    int m_owed[3];
    int m_sc  [3];
    int m_fc  [3];
    int scy   [3] = '{1, 3, 2};
    int maxc  [3] = '{15, 65535, 65535};

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_owed[i] = 0;
            m_sc[i]   = 0;
            m_fc[i]   = 0;
        end
    endfunction

    function automatic void model_update(input bit a, input bit b, input bit c);
        for (int i = 0; i < 3; i++) begin
            bit sinc = 1'b0;
            bit finc = 1'b0;
            if (b) begin
                m_owed[i] = 0;
                finc = 1'b1;
            end else if (m_owed[i] > 0) begin
                m_owed[i] = m_owed[i] - 1;
                sinc = 1'b1;
            end else if (a) begin
                m_owed[i] = scy[i] - 1;
                sinc = 1'b1;
            end
            if (c) begin
                m_sc[i] = 0;
                m_fc[i] = 0;
            end else begin
                if (sinc && m_sc[i] < maxc[i]) m_sc[i] = m_sc[i] + 1;
                if (finc && m_fc[i] < maxc[i]) m_fc[i] = m_fc[i] + 1;
            end
        end
    endfunction

    task automatic model_check();
        for (int i = 0; i < 3; i++) begin
            bit hold = (m_owed[i] > 0) || add_stall;
            chk($sformatf("pc_en[%0d]", i),        int'(o_pc[i]),  br ? 1 : (hold ? 0 : 1));
            chk($sformatf("if_of_en[%0d]", i),     int'(o_en[i]),  br ? 1 : (hold ? 0 : 1));
            chk($sformatf("if_of_flush[%0d]", i),  int'(o_fl[i]),  br ? 1 : 0);
            chk($sformatf("of_ex_bubble[%0d]", i), int'(o_bub[i]), (br || hold) ? 1 : 0);
            chk($sformatf("stalled[%0d]", i),      int'(o_st[i]),  (m_owed[i] > 0) ? 1 : 0);
            chk($sformatf("stall_count[%0d]", i),  int'(o_sc[i]),  m_sc[i]);
            chk($sformatf("flush_count[%0d]", i),  int'(o_fc[i]),  m_fc[i]);
        end
    endtask

    // Called at posedge+1: apply inputs, then compare at posedge+2.
    task automatic drive(input bit a, input bit b, input bit c);
        add_stall = a;
        br        = b;
        clr       = c;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update(add_stall, br, clr);
        #1;
    endtask

    typedef struct {
        bit as; bit br; bit clr;
        bit pc; bit en; bit fl; bit bub; bit st;
        int sc; int fc;
    } vec_t;

    vec_t tbl[11];
    int   stall_cycles;

    initial begin
        // Expected behaviour of the STALL_CYCLES=3 instance from a clean start.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4, 1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 2};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};

        rst = 1'b1;
        add_stall = 1'b0;
        br = 1'b0;
        clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        model_check();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset asserted mid-stall while add_stall is high.
        drive(1, 0, 0);
        tick();
        drive(1, 0, 0);
        chk("pre_reset_stalled_b", int'(if_b.stalled), 1);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_pc_en[%0d]", i),   int'(o_pc[i]),  1);
            chk($sformatf("rst_if_of_en[%0d]", i), int'(o_en[i]), 1);
            chk($sformatf("rst_bubble[%0d]", i),  int'(o_bub[i]), 0);
            chk($sformatf("rst_stalled[%0d]", i), int'(o_st[i]),  0);
            chk($sformatf("rst_stall_cnt[%0d]", i), int'(o_sc[i]), 0);
        end
        model_reset();
        add_stall = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        drive(0, 0, 0);
        tick();

        // Table-driven vectors against the STALL_CYCLES=3 instance.
        for (int r = 0; r < 11; r++) begin
            drive(tbl[r].as, tbl[r].br, tbl[r].clr);
            chk($sformatf("tbl%0d_pc_en", r),        int'(if_b.pc_en),        int'(tbl[r].pc));
            chk($sformatf("tbl%0d_if_of_en", r),     int'(if_b.if_of_en),     int'(tbl[r].en));
            chk($sformatf("tbl%0d_if_of_flush", r),  int'(if_b.if_of_flush),  int'(tbl[r].fl));
            chk($sformatf("tbl%0d_of_ex_bubble", r), int'(if_b.of_ex_bubble), int'(tbl[r].bub));
            chk($sformatf("tbl%0d_stalled", r),      int'(if_b.stalled),      int'(tbl[r].st));
            chk($sformatf("tbl%0d_stall_count", r),  int'(if_b.stall_count),  tbl[r].sc);
            chk($sformatf("tbl%0d_flush_count", r),  int'(if_b.flush_count),  tbl[r].fc);
            tick();
        end

        // Single hazard with STALL_CYCLES=1, then saturation of a 4-bit counter.
        drive(0, 0, 1);
        tick();
        drive(1, 0, 0);
        chk("sc1_pc_en_hazard", int'(if_a.pc_en), 0);
        tick();
        drive(0, 0, 0);
        chk("sc1_pc_en_after", int'(if_a.pc_en), 1);
        chk("sc1_stall_count", int'(if_a.stall_count), 1);
        tick();
        for (int k = 0; k < 20; k++) begin
            drive(1, 0, 0);
            tick();
            drive(0, 0, 0);
            tick();
        end
        drive(0, 0, 0);
        chk("sat_stall_count", int'(if_a.stall_count), 15);
        tick();
        drive(1, 0, 1);
        tick();
        drive(0, 0, 0);
        chk("clr_over_inc", int'(if_a.stall_count), 0);
        tick();

        // Back-to-back hazards with STALL_CYCLES=2: four bubbles, no gap.
        drive(0, 0, 1);
        tick();
        stall_cycles = 0;
        for (int k = 0; k < 5; k++) begin
            drive((k == 0 || k == 2) ? 1'b1 : 1'b0, 0, 0);
            if (!if_c.pc_en) stall_cycles++;
            if (k < 4) chk($sformatf("b2b_pc_en_c%0d", k), int'(if_c.pc_en), 0);
            if (k == 4) begin
                chk("b2b_pc_en_done", int'(if_c.pc_en), 1);
                chk("b2b_stall_count", int'(if_c.stall_count), 4);
            end
            tick();
        end
        chk("b2b_bubble_cycles", stall_cycles, 4);

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom % 3) == 0, ($urandom % 8) == 0, ($urandom % 32) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
